clashup_mem_arbiter: RTL and testbench

- Shares the single-port 256x8 clashup program/data RAM among NREQ requesters: CPU fetch/data port, hex loader, debug/host port.
- Round-robin arbitration with a valid/ready request handshake and a one-cycle response pulse.
- Sits between the requesters and the synchronous RAM macro; one access is in flight at a time.

---
 rtl/clashup_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_clashup_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clashup_mem_arbiter.sv
// clashup_mem_arbiter: round-robin arbiter sharing the single-port 256x8
// program/data RAM among NREQ requesters (0 = loader, 1 = CPU, 2 = debug).
// One access in flight: ARB (pick + capture) -> ISSUE (RAM strobe, ready) ->
// RESP (completion pulse, read data). mem_en/req_ready decode the registered
// ISSUE state together with a live recheck of the winner's req_valid, so a
// requester that withdraws before ISSUE is aborted without touching the RAM.
// Optional build macro CLASHUP_ARB_LOADER_PRIO_EN: requester 0 always wins
// in ARB when valid and does not advance the round-robin pointer.
module clashup_mem_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned AW   = 8,
   parameter int unsigned DW   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata,
   output logic               busy,
   output logic [15:0]        access_count
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StArb, StIssue, StResp} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   win_q;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [NREQ-1:0] rsp_valid_q;
   logic [15:0]     count_q;

   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   cand;
   logic [IW-1:0]   rr_next;
   logic            pick_we;
   logic [AW-1:0]   pick_addr;
   logic [DW-1:0]   pick_wdata;
   logic            issue_go;

   // Winner search: first valid requester scanning from rr_ptr upward, modulo NREQ
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IW'((32'(rr_ptr_q) + k) % NREQ);
         if (!pick_valid && req_valid[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
`ifdef CLASHUP_ARB_LOADER_PRIO_EN
      // Loader overrides the rotation whenever it is asking
      if (req_valid[0]) begin
         pick_valid = 1'b1;
         pick_idx   = '0;
      end
`endif
      rr_next = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
   end

   // Payload mux for the selected requester
   always_comb begin
      pick_we    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (pick_idx == IW'(k)) begin
            pick_we    = req_we[k];
            pick_addr  = req_addr[k*AW +: AW];
            pick_wdata = req_wdata[k*DW +: DW];
         end
      end
   end

   assign issue_go = (state_q == StIssue) && req_valid[win_q];

   // Next-state and round-robin pointer update
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         StArb: begin
            if (pick_valid) begin
               state_d = StIssue;
`ifdef CLASHUP_ARB_LOADER_PRIO_EN
               if (pick_idx != '0) rr_ptr_d = rr_next;
`else
               rr_ptr_d = rr_next;
`endif
            end
         end
         // Pointer already moved in ARB; an abort leaves it there
         StIssue: state_d = issue_go ? StResp : StArb;
         StResp:  state_d = StArb;
         default: state_d = StArb;
      endcase
   end

   // State and pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StArb;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Capture winner and payload in ARB only; later payload changes are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == StArb && pick_valid) begin
         win_q   <= pick_idx;
         we_q    <= pick_we;
         addr_q  <= pick_addr;
         wdata_q <= pick_wdata;
      end
   end

   // One-cycle completion pulse in RESP, one-hot on the winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= '0;
      end else begin
         rsp_valid_q <= '0;
         if (issue_go) rsp_valid_q[win_q] <= 1'b1;
      end
   end

   // Saturating count of completed accesses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (state_q == StResp && count_q != 16'hFFFF) begin
         count_q <= count_q + 16'd1;
      end
   end

   // Output decode; RAM-side signals are held at zero outside a live ISSUE
   always_comb begin
      mem_en    = issue_go;
      mem_we    = issue_go & we_q;
      mem_addr  = issue_go ? addr_q : '0;
      mem_wdata = issue_go ? wdata_q : '0;
      req_ready = '0;
      if (issue_go) req_ready[win_q] = 1'b1;
      rsp_valid    = rsp_valid_q;
      rsp_rdata    = (state_q == StResp && !we_q) ? mem_rdata : '0;
      busy         = (state_q != StArb);
      access_count = count_q;
   end

endmodule

// File: tb/tb_clashup_mem_arbiter.sv
// Directed bench for clashup_mem_arbiter with a behavioural 256x8 sync RAM.
// Honours CLASHUP_ARB_LOADER_PRIO_EN for the expected grant orders.
module tb_clashup_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_valid, req_we, req_ready, rsp_valid;
   logic [23:0] req_addr, req_wdata;
   logic [7:0]  rsp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_en, mem_we, busy;
   logic [15:0] access_count;

   always #5 clk = ~clk;

   clashup_mem_arbiter #(.NREQ(3), .AW(8), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .access_count(access_count)
   );

   // Synchronous RAM: read data appears the cycle after mem_en
   logic [7:0] ram [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata    <= ram[mem_addr];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         idx;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs[6];

   // Wait (bounded) for a nonzero req_ready, sampled at negedges
   task automatic wait_ready(output logic [2:0] vec, output int lat);
      vec = '0;
      lat = -1;
      for (int k = 1; k <= 6 && lat < 0; k++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            vec = req_ready;
            lat = k;
         end
      end
   endtask

   function automatic int onehot_idx(input logic [2:0] v);
      if (v == 3'b001) return 0;
      if (v == 3'b010) return 1;
      if (v == 3'b100) return 2;
      return -1;
   endfunction

   // Single-requester transaction; called at a negedge while the DUT is in ARB
   task automatic run_txn(input vec_t v, output int rdy_lat, output logic [2:0] rdy_vec,
                          output logic m_we, output logic [7:0] m_addr, output logic [7:0] m_wd,
                          output logic [2:0] rsp_vec, output logic [7:0] rdata);
      req_valid[v.idx]            = 1'b1;
      req_we[v.idx]               = v.we;
      req_addr[v.idx*8 +: 8]      = v.addr;
      req_wdata[v.idx*8 +: 8]     = v.wdata;
      wait_ready(rdy_vec, rdy_lat);
      m_we   = mem_we;
      m_addr = mem_addr;
      m_wd   = mem_wdata;
      @(posedge clk);
      #1 req_valid[v.idx] = 1'b0;
      @(negedge clk);
      rsp_vec = rsp_valid;
      rdata   = rsp_rdata;
   endtask

   int         exp_cont[6];
   int         exp_alt[4];
   logic [2:0] exp_abort_win;
   logic [7:0] exp_rd[3];

   initial begin
      int         lat, n, gi, ri;
      logic [2:0] rv, sv;
      logic       mw;
      logic [7:0] ma, md, rd;
      int         gidx[8];
      int         gcyc[8];

      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat, n, r;
      logic [2:0] rv, sv;
      logic       mw;
      logic [7:0] ma, md, rd;
      int         gidx[8];
      int         gcyc[8];

`ifdef CLASHUP_ARB_LOADER_PRIO_EN
      exp_cont      = '{0, 0, 0, 0, 0, 0};
      exp_alt       = '{0, 0, 0, 0};
      exp_abort_win = 3'b001;
`else
      exp_cont      = '{0, 1, 2, 0, 1, 2};
      exp_alt       = '{0, 1, 0, 1};
      exp_abort_win = 3'b100;
`endif
      // RAM contents once the table has run: 0x10=A5, 0xFF=3C, 0x00=5A
      exp_rd = '{8'hA5, 8'h3C, 8'h5A};

      //          idx we   addr   wdata  rdata  count
      vecs[0] = '{1, 1'b0, 8'h10, 8'h00, 8'hA5, 16'd1};
      vecs[1] = '{0, 1'b1, 8'hFF, 8'h3C, 8'h00, 16'd2};
      vecs[2] = '{2, 1'b0, 8'hFF, 8'h00, 8'h3C, 16'd3};
      vecs[3] = '{2, 1'b1, 8'h00, 8'h5A, 8'h00, 16'd4};
      vecs[4] = '{1, 1'b0, 8'h00, 8'h00, 8'h5A, 16'd5};
      vecs[5] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 16'd6};

      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      ram[8'h10] <= 8'hA5;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_handshake", 32'({req_ready, rsp_valid, mem_en, mem_we}), 32'd0);
      check("rst_mem_bus", 32'({mem_addr, mem_wdata, rsp_rdata}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(access_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table: one requester at a time
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i], lat, rv, mw, ma, md, sv, rd);
         check($sformatf("v%0d_ready_lat", i), 32'(lat), 32'd1);
         check($sformatf("v%0d_ready", i), 32'(rv), 32'(3'b001 << vecs[i].idx));
         check($sformatf("v%0d_mem_we", i), 32'(mw), 32'(vecs[i].we));
         check($sformatf("v%0d_mem_addr", i), 32'(ma), 32'(vecs[i].addr));
         if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), 32'(md), 32'(vecs[i].wdata));
         check($sformatf("v%0d_rsp_valid", i), 32'(sv), 32'(3'b001 << vecs[i].idx));
         check($sformatf("v%0d_rsp_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
         @(negedge clk);
         check($sformatf("v%0d_count", i), 32'(access_count), 32'(vecs[i].exp_count));
         check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      end

      // Contention: all three reading continuously from reset
      rst = 1'b1;
      req_we    = 3'b000;
      req_addr  = {8'h00, 8'hFF, 8'h10};
      req_valid = 3'b111;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (req_ready != 0 && n < 8) begin
            gidx[n] = onehot_idx(req_ready);
            gcyc[n] = c;
            n++;
         end
         if (rsp_valid != 0) begin
            r = onehot_idx(rsp_valid);
            check($sformatf("cont_rsp_onehot_c%0d", c), 32'(r >= 0), 32'd1);
            if (r >= 0) check($sformatf("cont_rdata_c%0d", c), 32'(rsp_rdata), 32'(exp_rd[r]));
         end
      end
      req_valid = '0;
      check("cont_grants", 32'(n), 32'd6);
      for (int g = 0; g < 6 && g < n; g++) begin
         check($sformatf("cont_grant%0d_idx", g), 32'(gidx[g]), 32'(exp_cont[g]));
         check($sformatf("cont_grant%0d_cycle", g), 32'(gcyc[g]), 32'(1 + 3 * g));
      end
      check("cont_count18", 32'(access_count), 32'd6);

      // Abort: req1 valid for its ARB sample only
      req_valid[1] = 1'b1;
      req_addr[15:8] = 8'h10;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(negedge clk);
      check("abort_busy_issue", 32'(busy), 32'd1);
      check("abort_no_strobe", 32'({mem_en, req_ready}), 32'd0);
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check("abort_back_arb", 32'(busy), 32'd0);
      check("abort_count", 32'(access_count), 32'd6);
      req_valid = 3'b101;
      wait_ready(rv, lat);
      check("abort_next_winner", 32'(rv), 32'(exp_abort_win));
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check("abort_next_rsp", 32'(rsp_valid), 32'(exp_abort_win));
      r = onehot_idx(exp_abort_win);
      check("abort_next_rdata", 32'(rsp_rdata), 32'(exp_rd[r]));
      @(negedge clk);

      // Reset asserted while the access sits in RESP
      req_valid[1] = 1'b1;
      req_addr[15:8] = 8'hFF;
      wait_ready(rv, lat);
      check("rstmid_ready", 32'(rv), 32'b010);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_rsp", 32'(rsp_valid), 32'd0);
      check("rstmid_outs", 32'({req_ready, mem_en, mem_we, mem_addr, rsp_rdata}), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_count", 32'(access_count), 32'd0);
      rst = 1'b0;
      // rr_ptr back at 0: loader beats debug
      req_valid = 3'b101;
      wait_ready(rv, lat);
      check("rstmid_next_ready", 32'(rv), 32'b001);
      check("rstmid_next_lat", 32'(lat), 32'd1);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check("rstmid_next_rdata", 32'(rsp_rdata), 32'h0000_00A5);
      @(negedge clk);
      check("rstmid_next_count", 32'(access_count), 32'd1);

      // Loader and CPU held valid: alternate, or loader starves CPU under priority
      rst = 1'b1;
      req_valid = 3'b011;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (req_ready != 0 && n < 8) begin
            gidx[n] = onehot_idx(req_ready);
            n++;
         end
      end
      req_valid = '0;
      check("alt_grants", 32'(n), 32'd4);
      for (int g = 0; g < 4 && g < n; g++)
         check($sformatf("alt_grant%0d", g), 32'(gidx[g]), 32'(exp_alt[g]));
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
